dcache_qspi: RTL and testbench

//  Memory-side line mover for the data cache. Runs line fills (pull) and write-backs (push) against an external quad-SPI PSRAM.

---
 rtl/dcache_qspi_pkg.sv | 41 ++++
 rtl/dcache_qspi_nibble_shift.sv | 37 +++
 rtl/dcache_qspi.sv | 172 +++++++++++++++++
 tb/tb_dcache_qspi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_qspi_pkg.sv
// Shared types and constants for the data-cache QSPI line mover.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Macro DCACHE_QSPI_QPI_CMD_EN selects a quad command phase.
package dcache_qspi_pkg;

    // Transaction state machine states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WCAP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_CSH,
        ST_WFILL
    } state_t;

    // Width of the per-state item counter; large enough for the serial command (8 bits)
    localparam int CNT_W        = 4;
    localparam int ADDR_NIBBLES = 6;

    localparam logic [7:0] DEF_CMD_READ  = 8'hEB;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h38;

`ifdef DCACHE_QSPI_QPI_CMD_EN
    // Command goes out as two quad nibbles
    localparam int CMD_ITEMS = 2;
`else
    // Command goes out one bit per SPI clock on io0
    localparam int CMD_ITEMS = 8;
`endif

    // Nibble idx of a 24-bit address, MSB nibble first
    function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [CNT_W-1:0] idx);
        logic [23:0] sh;
        sh = addr << (4 * idx);
        return sh[23:20];
    endfunction

endpackage

// File: rtl/dcache_qspi_nibble_shift.sv
// Bit/nibble timebase: two-clk nibble time (phase, sclk), per-state item counter and terminal flag.
// Latency: term is combinational from the counter; counter wraps to zero on the terminal cycle.
// Backpressure: none; runs whenever en is high, fast mode steps one item per clk with sclk held low.
module qspi_nibble_shift
    import dcache_qspi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fast,
    input  logic [CNT_W-1:0] last,
    output logic             phase,
    output logic             sclk,
    output logic             term,
    output logic [CNT_W-1:0] cnt
);

    // Last item of the current state reached (slow items end on phase 1)
    assign term = en && (cnt == last) && (fast || phase);
    assign sclk = en && !fast && phase;

    // Phase toggles every clk in slow mode; counter restarts at each state boundary
    always_ff @(posedge clk) begin
        if (reset || !en || term) begin
            phase <= 1'b0;
            cnt   <= '0;
        end else if (fast) begin
            cnt <= cnt + 1'b1;
        end else begin
            phase <= ~phase;
            if (phase) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_qspi.sv
// Data-cache line mover: line fill (pull) and write-back (push) against a quad-SPI PSRAM.
// Latency: write req->done = 8 + 2*(cmd items + 6 + 8) + CS_HIGH clk; read adds dummies and an 8-clk cache fill.
// Backpressure: req is only sampled in IDLE; cache strobes are 8 gap-free cycles. Macro DCACHE_QSPI_QPI_CMD_EN.
module dcache_qspi
    import dcache_qspi_pkg::*;
#(
    parameter int         PA          = 22,
    parameter int         LINE_LENGTH = 4,
    parameter int         DUMMY       = 6,
    parameter int         CS_HIGH     = 2,
    parameter logic [7:0] CMD_READ    = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE   = DEF_CMD_WRITE
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          push,
    input  logic          pull,
    input  logic [PA-3:0] tag,
    input  logic [3:0]    dwrite,
    output logic [3:0]    dread,
    output logic          rstrobe_d,
    output logic          wstrobe_d,
    output logic          busy,
    output logic          done,
    output logic          qspi_cs_n,
    output logic          qspi_sclk,
    output logic [3:0]    qspi_o,
    output logic [3:0]    qspi_oe,
    input  logic [3:0]    qspi_i
);

    localparam int               NIBBLES   = 2 * LINE_LENGTH;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NIBBLES - 1);

    state_t           state;
    state_t           next_state;
    logic             is_wr;
    logic [3:0]       line_buf [NIBBLES];
    logic             en;
    logic             fast;
    logic             phase;
    logic             term;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      addr;
    logic [7:0]       cmd;
`ifndef DCACHE_QSPI_QPI_CMD_EN
    logic [2:0]       cmd_bit;
`endif

    // Byte address of the line, zero-extended to the 24-bit PSRAM address
    assign addr = 24'({tag, 2'b00});
    assign cmd  = is_wr ? CMD_WRITE : CMD_READ;

    qspi_nibble_shift u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .fast  (fast),
        .last  (last),
        .phase (phase),
        .sclk  (qspi_sclk),
        .term  (term),
        .cnt   (cnt)
    );

    // Per-state item count and timebase mode (cache-side and CS gap states are one item per clk)
    always_comb begin
        en   = (state != ST_IDLE);
        fast = (state == ST_WCAP) || (state == ST_CSH) || (state == ST_WFILL);
        case (state)
            ST_CMD:   last = CNT_W'(CMD_ITEMS - 1);
            ST_ADDR:  last = CNT_W'(ADDR_NIBBLES - 1);
            ST_DUMMY: last = CNT_W'(DUMMY - 1);
            ST_CSH:   last = CNT_W'(CS_HIGH - 1);
            default:  last = LAST_DATA;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Direction of the accepted transaction; push wins over pull
    always_ff @(posedge clk) begin
        if (reset) begin
            is_wr <= 1'b0;
        end else if (state == ST_IDLE && req && (push || pull)) begin
            is_wr <= push;
        end
    end

    // Line buffer: filled from the cache on write-back, from the pads at the end of each read nibble
    always_ff @(posedge clk) begin
        if (state == ST_WCAP) begin
            line_buf[cnt[2:0]] <= dwrite;
        end else if (state == ST_RDATA && phase) begin
            line_buf[cnt[2:0]] <= qspi_i;
        end
    end

    // Next-state logic; every non-idle state ends on the timebase terminal flag
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req && (push || pull)) next_state = push ? ST_WCAP : ST_CMD;
            ST_WCAP:  if (term) next_state = ST_CMD;
            ST_CMD:   if (term) next_state = ST_ADDR;
            ST_ADDR:  if (term) next_state = is_wr ? ST_WDATA : ST_DUMMY;
            ST_DUMMY: if (term) next_state = ST_RDATA;
            ST_WDATA: if (term) next_state = ST_CSH;
            ST_RDATA: if (term) next_state = ST_CSH;
            ST_CSH:   if (term) next_state = is_wr ? ST_IDLE : ST_WFILL;
            ST_WFILL: if (term) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Pad and cache-side outputs decoded from state and item counter
    always_comb begin
        qspi_cs_n = 1'b1;
        qspi_o    = 4'h0;
        qspi_oe   = 4'h0;
        rstrobe_d = 1'b0;
        wstrobe_d = 1'b0;
        dread     = 4'h0;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
`ifndef DCACHE_QSPI_QPI_CMD_EN
        cmd_bit   = 3'd7 - cnt[2:0];
`endif
        case (state)
            ST_WCAP: rstrobe_d = 1'b1;
            ST_CMD: begin
                qspi_cs_n = 1'b0;
`ifdef DCACHE_QSPI_QPI_CMD_EN
                qspi_oe   = 4'hF;
                qspi_o    = (cnt == '0) ? cmd[7:4] : cmd[3:0];
`else
                qspi_oe   = 4'b0001;
                qspi_o    = {3'b000, cmd[cmd_bit]};
`endif
            end
            ST_ADDR: begin
                qspi_cs_n = 1'b0;
                qspi_oe   = 4'hF;
                qspi_o    = addr_nibble(addr, cnt);
            end
            ST_DUMMY, ST_RDATA: qspi_cs_n = 1'b0;
            ST_WDATA: begin
                qspi_cs_n = 1'b0;
                qspi_oe   = 4'hF;
                qspi_o    = line_buf[cnt[2:0]];
            end
            // Write-back ends here; a fill still has the cache strobes to go
            ST_CSH: done = term && is_wr;
            ST_WFILL: begin
                wstrobe_d = 1'b1;
                dread     = line_buf[cnt[2:0]];
                done      = term;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_qspi.sv
// Directed bench for dcache_qspi with a small PSRAM/cache model on the negative clock edge.
// Latency: expected cycle counts are hand-derived per build (DCACHE_QSPI_QPI_CMD_EN or serial command).
// Backpressure: n/a; the cache model answers every rstrobe_d in the same cycle.
`timescale 1ns/1ps
module tb_dcache_qspi;

`ifdef DCACHE_QSPI_QPI_CMD_EN
    localparam int CMDN = 2;
`else
    localparam int CMDN = 8;
`endif
    // Cycle from req cycle to done cycle
    localparam int WR_CYC = 8 + 2 * (CMDN + 6 + 8) + 2;
    localparam int RD_CYC = 2 * (CMDN + 6 + 6 + 8) + 2 + 8;
    // SPI clocks before the first read data nibble
    localparam int PRE_RD = CMDN + 6 + 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        push = 1'b0;
    logic        pull = 1'b0;
    logic [19:0] tag = '0;
    logic [3:0]  dwrite = 4'h0;
    logic [3:0]  dread;
    logic        rstrobe_d;
    logic        wstrobe_d;
    logic        busy;
    logic        done;
    logic        qspi_cs_n;
    logic        qspi_sclk;
    logic [3:0]  qspi_o;
    logic [3:0]  qspi_oe;
    logic [3:0]  qspi_i = 4'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor / model state (written only by the monitor)
    logic [7:0] bus_q [$];
    int bit_n = 0;
    int csh_run = 100;
    int csh_last = 0;
    int rs_tot = 0, rs_first = 0, rs_lastc = 0;
    int ws_tot = 0, ws_first = 0, ws_lastc = 0;
    int done_tot = 0;
    logic rs_prev = 1'b0, ws_prev = 1'b0;
    logic [3:0] rd_got [8];

    // Stimulus tables (written only by the main initial block)
    logic [3:0] wr_nib [8];
    logic [3:0] rd_nib [8];
    logic [7:0] exp_q [$];

    dcache_qspi dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .push      (push),
        .pull      (pull),
        .tag       (tag),
        .dwrite    (dwrite),
        .dread     (dread),
        .rstrobe_d (rstrobe_d),
        .wstrobe_d (wstrobe_d),
        .busy      (busy),
        .done      (done),
        .qspi_cs_n (qspi_cs_n),
        .qspi_sclk (qspi_sclk),
        .qspi_o    (qspi_o),
        .qspi_oe   (qspi_oe),
        .qspi_i    (qspi_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM and cache model, sampled mid-cycle
    always @(negedge clk) begin
        if (!qspi_cs_n) begin
            if (csh_run != 0) csh_last = csh_run;
            csh_run = 0;
            if (qspi_sclk) begin
                bus_q.push_back({qspi_oe, qspi_o});
                if (bit_n >= PRE_RD && bit_n < PRE_RD + 8) qspi_i = rd_nib[bit_n - PRE_RD];
                bit_n++;
            end
        end else begin
            bit_n = 0;
            csh_run++;
        end
        if (rstrobe_d) begin
            if (!rs_prev) rs_first = cyc;
            dwrite = wr_nib[(cyc - rs_first) & 7];
            rs_lastc = cyc;
            rs_tot++;
        end
        rs_prev = rstrobe_d;
        if (wstrobe_d) begin
            if (!ws_prev) ws_first = cyc;
            rd_got[(cyc - ws_first) & 7] = dread;
            ws_lastc = cyc;
            ws_tot++;
        end
        ws_prev = wstrobe_d;
        if (done) done_tot++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic exp_cmd(input logic [7:0] c);
`ifdef DCACHE_QSPI_QPI_CMD_EN
        exp_q.push_back({4'hF, c[7:4]});
        exp_q.push_back({4'hF, c[3:0]});
`else
        for (int i = 7; i >= 0; i--) exp_q.push_back({4'b0001, 3'b000, c[i]});
`endif
    endtask

    task automatic exp_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) exp_q.push_back({4'hF, a[i*4 +: 4]});
    endtask

    task automatic check_bus(input string name, input int base);
        logic [7:0] a;
        check({name, "_len"}, 32'(bus_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < bus_q.size(); i++) begin
            a = bus_q[base + i];
            if (exp_q[i][7:4] == 4'h0) a[3:0] = 4'h0;
            check($sformatf("%s_nib%0d", name, i), 32'(a), 32'(exp_q[i]));
        end
    endtask

    task automatic wait_done(input string name, output int dc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        if (done !== 1'b1) check({name, "_timeout"}, 32'(0), 32'(1));
        dc = cyc;
    endtask

    task automatic check_idle(input string name);
        check({name, "_cs_n"}, 32'(qspi_cs_n), 32'(1));
        check({name, "_sclk"}, 32'(qspi_sclk), 32'(0));
        check({name, "_oe_o"}, 32'({qspi_oe, qspi_o}), 32'(0));
        check({name, "_strb"}, 32'({rstrobe_d, wstrobe_d}), 32'(0));
        check({name, "_busy_done"}, 32'({busy, done}), 32'(0));
        check({name, "_dread"}, 32'(dread), 32'(0));
    endtask

    // Full pull: checks bus, timing, strobes and the reassembled line
    task automatic run_pull(input string name, input logic [19:0] t, input logic [23:0] a, input logic [31:0] line);
        int base, wsb, t0, dc;
        logic [31:0] got;
        exp_q.delete();
        exp_cmd(8'hEB);
        exp_addr(a);
        for (int i = 0; i < 14; i++) exp_q.push_back(8'h00);
        base = bus_q.size();
        wsb = ws_tot;
        req = 1'b1; pull = 1'b1; push = 1'b0; tag = t; t0 = cyc;
        tick;
        req = 1'b0; pull = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'(1));
        wait_done(name, dc);
        check({name, "_cycles"}, 32'(dc - t0), 32'(RD_CYC));
        check({name, "_done_with_wstrb"}, 32'(wstrobe_d), 32'(1));
        check({name, "_ws_count"}, 32'(ws_tot - wsb), 32'(8));
        check({name, "_ws_span"}, 32'(ws_lastc - ws_first), 32'(7));
        got = {rd_got[6], rd_got[7], rd_got[4], rd_got[5], rd_got[2], rd_got[3], rd_got[0], rd_got[1]};
        check({name, "_line"}, got, line);
        tick;
        check({name, "_after"}, 32'({busy, done, wstrobe_d}), 32'(0));
        check_bus(name, base);
    endtask

    initial begin
        int base, rsb, t0, dc, d1, d2, n, dtot;

        // Reset
        tick; tick;
        check_idle("reset");
        reset = 1'b0;
        tick;

        // Push: tag 0x00040 -> address 0x000100, line 0x12345678
        wr_nib = '{4'h7, 4'h8, 4'h5, 4'h6, 4'h3, 4'h4, 4'h1, 4'h2};
        exp_q.delete();
        exp_cmd(8'h38);
        exp_addr(24'h000100);
        for (int i = 0; i < 8; i++) exp_q.push_back({4'hF, wr_nib[i]});
        base = bus_q.size();
        rsb = rs_tot;
        req = 1'b1; push = 1'b1; pull = 1'b0; tag = 20'h00040; t0 = cyc;
        tick;
        req = 1'b0; push = 1'b0;
        check("push_busy", 32'(busy), 32'(1));
        wait_done("push", dc);
        check("push_cycles", 32'(dc - t0), 32'(WR_CYC));
        check("push_done_cs_n", 32'(qspi_cs_n), 32'(1));
        check("push_rs_count", 32'(rs_tot - rsb), 32'(8));
        check("push_rs_span", 32'(rs_lastc - rs_first), 32'(7));
        check("push_rs_start", 32'(rs_first - t0), 32'(1));
        tick;
        check("push_after", 32'({busy, done}), 32'(0));
        check_bus("push", base);

        // Pull: PSRAM returns A,B,C,D,E,F,0,1 -> line 0x01EFCDAB
        rd_nib = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        run_pull("pull1", 20'hABCDE, 24'h2AF378, 32'h01EFCDAB);

        // Reset during ADDR
        req = 1'b1; pull = 1'b1; tag = 20'h00040;
        base = bus_q.size();
        tick;
        req = 1'b0; pull = 1'b0;
        n = 0;
        while (bus_q.size() - base < CMDN + 2 && n < 200) begin tick; n++; end
        check("rst_addr_reach", 32'(bus_q.size() - base >= CMDN + 2), 32'(1));
        dtot = done_tot;
        reset = 1'b1;
        tick;
        check_idle("rst_addr");
        reset = 1'b0;
        tick; tick; tick;
        check("rst_addr_no_done", 32'(done_tot - dtot), 32'(0));

        // Reset during WFILL
        req = 1'b1; pull = 1'b1; tag = 20'h00040;
        rsb = ws_tot;
        tick;
        req = 1'b0; pull = 1'b0;
        n = 0;
        while (ws_tot - rsb < 3 && n < 200) begin tick; n++; end
        check("rst_wfill_reach", 32'(ws_tot - rsb), 32'(3));
        dtot = done_tot;
        reset = 1'b1;
        tick;
        check_idle("rst_wfill");
        reset = 1'b0;
        tick; tick; tick;
        check("rst_wfill_no_done", 32'(done_tot - dtot), 32'(0));

        // Fresh pull after reset: 1..8 -> line 0x78563412
        rd_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_pull("pull2", 20'h00040, 24'h000100, 32'h78563412);

        // req with neither push nor pull is ignored
        req = 1'b1; push = 1'b0; pull = 1'b0;
        tick; tick;
        check("noop_busy", 32'(busy), 32'(0));
        check("noop_cs_n", 32'(qspi_cs_n), 32'(1));
        req = 1'b0;
        tick;

        // Back-to-back: req held through done
        req = 1'b1; pull = 1'b1; tag = 20'hABCDE; t0 = cyc;
        wait_done("b2b1", d1);
        check("b2b1_cycles", 32'(d1 - t0), 32'(RD_CYC));
        tick;
        check("b2b_gap_busy", 32'(busy), 32'(0));
        tick;
        check("b2b_restart_busy", 32'(busy), 32'(1));
        req = 1'b0; pull = 1'b0;
        wait_done("b2b2", d2);
        check("b2b2_cycles", 32'(d2 - (d1 + 1)), 32'(RD_CYC));
        check("b2b_cs_high_min", 32'(csh_last >= 2), 32'(1));
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
